// File: rtl/lcd_pkg.sv
// Shared constants, FSM state type and DDRAM address decode for the LCD bus decoder.
package lcd_pkg;

  localparam logic [7:0]  CMD_CLEAR  = 8'h01;
  localparam logic [7:0]  CHAR_SPACE = 8'h20;
  localparam logic [6:0]  ROW1_BASE  = 7'h40;
  localparam int unsigned LCD_CELLS  = 32;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } lcd_state_e;

  // Map a 7-bit DDRAM address to {valid, cell index}; only 0x00-0x0F and 0x40-0x4F are mapped.
  function automatic logic [5:0] ddram_decode(input logic [6:0] a);
    logic [5:0] r;
    r = '0;
    if (a[6:4] == 3'b000) begin
      r = {1'b1, 1'b0, a[3:0]};
    end else if (a[6:4] == ROW1_BASE[6:4]) begin
      r = {1'b1, 1'b1, a[3:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/lcd_e_fall_det.sv
// Input register stage for the LCD bus and registered lcd_e falling-edge strobe.
module lcd_e_fall_det (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e_i,
  input  logic       lcd_rs_i,
  input  logic       lcd_rw_i,
  input  logic [7:0] lcd_data_i,
  output logic       xfer_o,
  output logic       rs_o,
  output logic       rw_o,
  output logic [7:0] data_o
);

  logic       e_q, e_prev_q, rs_q, rw_q;
  logic [7:0] data_q;
  logic       xfer_q, xrs_q, xrw_q;
  logic [7:0] xdata_q;

  // Capture the bus once, then strobe one cycle after registered lcd_e has dropped,
  // carrying the rs/rw/data that were registered alongside the low lcd_e sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q      <= 1'b0;
      e_prev_q <= 1'b0;
      rs_q     <= 1'b0;
      rw_q     <= 1'b0;
      data_q   <= '0;
      xfer_q   <= 1'b0;
      xrs_q    <= 1'b0;
      xrw_q    <= 1'b0;
      xdata_q  <= '0;
    end else begin
      e_q      <= lcd_e_i;
      e_prev_q <= e_q;
      rs_q     <= lcd_rs_i;
      rw_q     <= lcd_rw_i;
      data_q   <= lcd_data_i;
      xfer_q   <= e_prev_q & ~e_q;
      xrs_q    <= rs_q;
      xrw_q    <= rw_q;
      xdata_q  <= data_q;
    end
  end

  assign xfer_o = xfer_q;
  assign rs_o   = xrs_q;
  assign rw_o   = xrw_q;
  assign data_o = xdata_q;

endmodule

// File: rtl/lcd_bus_decoder.sv
// Decodes text-LCD bus writes into a 2x16 shadow display with cursor and command tracking.
module lcd_bus_decoder
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [4:0] cursor,
  output logic       busy,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic       char_valid,
  output logic       overrun,
  output logic       addr_err
);

  localparam logic [4:0] LAST_IDX = 5'(LCD_CELLS - 1);

  logic       xfer, x_rs, x_rw;
  logic [7:0] x_data;

  lcd_e_fall_det u_fall_det (
    .clk       (clk),
    .rst       (rst),
    .lcd_e_i   (lcd_e),
    .lcd_rs_i  (lcd_rs),
    .lcd_rw_i  (lcd_rw),
    .lcd_data_i(lcd_data),
    .xfer_o    (xfer),
    .rs_o      (x_rs),
    .rw_o      (x_rw),
    .data_o    (x_data)
  );

  lcd_state_e state_q, state_d;
  logic [4:0] clr_idx_q, clr_idx_d;
  logic [4:0] cursor_q, cursor_d;
  logic       inc_q, inc_d;
  logic [7:0] cmd_code_q, cmd_code_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic       char_valid_q, char_valid_d;
  logic       overrun_q, overrun_d;
  logic       addr_err_q, addr_err_d;

  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_q [LCD_CELLS];
  logic [5:0] ddram;

  // Control state and response pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_CLEAR;
      clr_idx_q    <= '0;
      cursor_q     <= '0;
      inc_q        <= 1'b1;
      cmd_code_q   <= '0;
      cmd_valid_q  <= 1'b0;
      char_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      cursor_q     <= cursor_d;
      inc_q        <= inc_d;
      cmd_code_q   <= cmd_code_d;
      cmd_valid_q  <= cmd_valid_d;
      char_valid_q <= char_valid_d;
      overrun_q    <= overrun_d;
      addr_err_q   <= addr_err_d;
    end
  end

  // Shadow display cells; contents are initialised by the CLEAR pass, not by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  // Next-state, cell write and response decode for each accepted transfer.
  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    cursor_d     = cursor_q;
    inc_d        = inc_q;
    cmd_code_d   = cmd_code_q;
    cmd_valid_d  = 1'b0;
    char_valid_d = 1'b0;
    overrun_d    = 1'b0;
    addr_err_d   = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = cursor_q;
    mem_wdata    = x_data;
    ddram        = ddram_decode(x_data[6:0]);

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_idx_q;
        mem_wdata = CHAR_SPACE;
        cursor_d  = '0;
        inc_d     = 1'b1;
        clr_idx_d = clr_idx_q + 5'd1;
        if (clr_idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end
        if (xfer && !x_rw) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        if (xfer && !x_rw) begin
          if (x_rs) begin
            mem_we       = 1'b1;
            char_valid_d = 1'b1;
            cursor_d     = inc_q ? cursor_q + 5'd1 : cursor_q - 5'd1;
          end else begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = x_data;
            if (x_data == CMD_CLEAR) begin
              state_d   = ST_CLEAR;
              clr_idx_d = '0;
            end else if (x_data[7]) begin
              if (ddram[5]) begin
                cursor_d = ddram[4:0];
              end else begin
                addr_err_d = 1'b1;
              end
            end else if (x_data[7:1] == 7'h01) begin
              cursor_d = '0;
            end else if (x_data[7:2] == 6'h01) begin
              inc_d = x_data[1];
            end
          end
        end
      end
    endcase
  end

  assign busy       = (state_q == ST_CLEAR);
  assign cursor     = busy ? '0 : cursor_q;
  assign rd_char    = mem_q[rd_addr];
  assign cmd_code   = cmd_code_q;
  assign cmd_valid  = cmd_valid_q;
  assign char_valid = char_valid_q;
  assign overrun    = overrun_q;
  assign addr_err   = addr_err_q;

endmodule

// File: doc/lcd_bus_decoder.md
LCD_BUS_DECODER -- requirements
Module: lcd_bus_decoder

Interface
REQ-001 Parameter: none; depth fixed at 32 cells (2 rows x 16 columns).
REQ-002 clk  input  1  system clock; single clock domain.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 lcd_e  input  1  text-LCD enable, as driven by the mode mux; a write is latched on its falling edge.
REQ-005 lcd_rs  input  1  0 = command, 1 = character data.
REQ-006 lcd_rw  input  1  0 = write, 1 = read.
REQ-007 lcd_data  input  8  LCD data bus.
REQ-008 rd_addr  input  5  shadow-display read index; 0-15 = row 0, 16-31 = row 1.
REQ-009 rd_char  output  8  shadow-display byte at rd_addr; combinational read.
REQ-010 cursor  output  5  current write index.
REQ-011 busy  output  1  high while the clear sequence runs.
REQ-012 cmd_valid  output  1  one-cycle pulse per accepted command.
REQ-013 cmd_code  output  8  last accepted command byte.
REQ-014 char_valid  output  1  one-cycle pulse per stored character.
REQ-015 overrun  output  1  one-cycle pulse when a transfer arrives while busy.
REQ-016 addr_err  output  1  one-cycle pulse on an unmapped set-DDRAM address.

Function
REQ-017 Register lcd_e, lcd_rs, lcd_rw and lcd_data once; a transfer is the cycle where registered lcd_e goes 1->0, using the registered rs/rw/data.
REQ-018 Response pulses assert exactly 2 clk cycles after the first cycle in which input lcd_e is sampled low.
REQ-019 Ignore transfers with rw=1: no pulse and no state change.
REQ-020 FSM states: CLEAR and IDLE only.
REQ-021 CLEAR: write 8'h20 to one cell per cycle, index 0..31 (32 cycles), then go to IDLE.
REQ-022 CLEAR: hold busy=1 and force cursor=0.
REQ-023 CLEAR: set the entry direction to increment.
REQ-024 Any write transfer in CLEAR is dropped and pulses overrun; the clear sequence continues.
REQ-025 IDLE, rs=0, data=8'h01: pulse cmd_valid and enter CLEAR on the next cycle.
REQ-026 IDLE, rs=0, data=8'h02 or 8'h03: set cursor=0; memory unchanged.
REQ-027 IDLE, rs=0, data 8'h04-8'h07: entry direction = data[1] (1 = increment, 0 = decrement).
REQ-028 IDLE, rs=0, data[7]=1, with a=data[6:0]: a in 0x00-0x0F sets cursor=a; a in 0x40-0x4F sets cursor=16+a[3:0].
REQ-029 IDLE, rs=0, data[7]=1, any other a: pulse addr_err; cursor unchanged; cmd_valid still pulses.
REQ-030 All other command bytes (function set, display control, shift, CGRAM address): pulse cmd_valid only.
REQ-031 Every accepted command updates cmd_code.
REQ-032 IDLE, rs=1: write data to cell[cursor], pulse char_valid, then step cursor.
REQ-033 Cursor stepping: increment wraps 31->0; decrement wraps 0->31; 5-bit modular arithmetic.
REQ-034 Cursor crossing 15->16 and 16->15 is continuous; row boundaries have no special handling.

Reset
REQ-035 rst asserted: state=CLEAR, clear index=0, cursor=0, entry=increment, cmd_code=8'h00.
REQ-036 rst asserted: all pulse outputs 0; busy=1; input registers 0.
REQ-037 Cell contents are not reset directly; the CLEAR pass after reset release initialises them.
REQ-038 rst asserted mid-CLEAR or mid-transfer aborts the current operation; the clear restarts from index 0.

Structure
REQ-039 Shared package lcd_pkg holds CMD_CLEAR=8'h01, CHAR_SPACE=8'h20, ROW1_BASE=7'h40, LCD_CELLS=32 and the FSM state enum.
REQ-040 One sub-module, lcd_e_fall_det, contains the input register and the falling-edge pulse logic; everything else is in lcd_bus_decoder.

Verification
REQ-041 Release rst and wait 32 cycles -> busy falls on cycle 32; every rd_char = 8'h20; cursor=0.
REQ-042 Write "HI" (rs=1, 8'h48, then 8'h49) -> cell0=8'h48, cell1=8'h49, cursor=2, two char_valid pulses, each at +2 cycles.
REQ-043 Command 8'hC5, then char 8'h41 -> cell21=8'h41, cursor=22; command 8'hA0 -> addr_err pulse, cursor stays 22.
REQ-044 Command 8'h04, cursor=0, write 8'h5A -> cell0=8'h5A, cursor=31.
REQ-045 Command 8'h01, then a char write 5 cycles later -> overrun pulse; char dropped; all cells 8'h20 after 32 cycles.
REQ-046 rst pulsed mid-sequence at cursor=10 -> outputs reach reset values immediately; a full clear follows; cursor=0.
